// File: rtl/brush_stamp_writer.sv
// Square brush stamp writer: latches cursor, radius and material on a draw request,
// then walks the clipped square row-major, one VRAM write per granted cycle.
module brush_stamp_writer #(
  parameter int COLUMNS    = 640,
  parameter int ROWS       = 400,
  parameter int ADDR_WIDTH = $clog2(COLUMNS*ROWS),
  parameter int DATA_WIDTH = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         draw_en_i,
  input  logic [2:0]                   brush_radius_i,
  input  logic [DATA_WIDTH-1:0]        material_i,
  input  logic [$clog2(COLUMNS)-1:0]   mouse_x_position_i,
  input  logic [$clog2(ROWS)-1:0]      mouse_y_position_i,
  input  logic                         wr_grant_i,
  output logic [ADDR_WIDTH-1:0]        wr_address_o,
  output logic [DATA_WIDTH-1:0]        wr_data_o,
  output logic                         wr_en_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int XW = $clog2(COLUMNS);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0]         X_MAX    = XW'(COLUMNS-1);
  localparam logic [YW-1:0]         Y_MAX    = YW'(ROWS-1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(COLUMNS);

  // state  | meaning
  // IDLE   | waiting for draw_en_i ; SETUP | bounds + first address
  // SWEEP  | one write per grant    ; DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SWEEP, S_DONE} state_t;

  state_t                r_state;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [2:0]            r_rad;
  logic [DATA_WIDTH-1:0] r_mat;
  logic [XW-1:0]         r_x_lo;
  logic [XW-1:0]         r_x_hi;
  logic [YW-1:0]         r_y_hi;
  logic [XW-1:0]         r_cur_x;
  logic [YW-1:0]         r_cur_y;
  logic [ADDR_WIDTH-1:0] r_row_base;

  logic [XW-1:0]         w_x_clamp;
  logic [YW-1:0]         w_y_clamp;
  logic [XW-1:0]         w_x_rad;
  logic [YW-1:0]         w_y_rad;
  logic [XW:0]           w_x_sum;
  logic [YW:0]           w_y_sum;
  logic [XW-1:0]         w_x_lo;
  logic [XW-1:0]         w_x_hi;
  logic [YW-1:0]         w_y_lo;
  logic [YW-1:0]         w_y_hi;
  logic [ADDR_WIDTH-1:0] w_row_lo;
  logic [ADDR_WIDTH-1:0] w_first_addr;
  logic [ADDR_WIDTH-1:0] w_next_row;
  logic                  w_accept;
  logic                  w_last_col;
  logic                  w_last_row;

  assign w_x_clamp = (mouse_x_position_i > X_MAX) ? X_MAX : mouse_x_position_i;
  assign w_y_clamp = (mouse_y_position_i > Y_MAX) ? Y_MAX : mouse_y_position_i;

  // Widened sums so x+r / y+r near the far edge never wrap before clipping
  assign w_x_rad = XW'(r_rad);
  assign w_y_rad = YW'(r_rad);
  assign w_x_sum = {1'b0, r_x} + {1'b0, w_x_rad};
  assign w_y_sum = {1'b0, r_y} + {1'b0, w_y_rad};
  assign w_x_lo  = (r_x >= w_x_rad) ? (r_x - w_x_rad) : '0;
  assign w_y_lo  = (r_y >= w_y_rad) ? (r_y - w_y_rad) : '0;
  assign w_x_hi  = (w_x_sum > {1'b0, X_MAX}) ? X_MAX : w_x_sum[XW-1:0];
  assign w_y_hi  = (w_y_sum > {1'b0, Y_MAX}) ? Y_MAX : w_y_sum[YW-1:0];

  assign w_row_lo     = ADDR_WIDTH'(w_y_lo) * ROW_STEP;
  assign w_first_addr = w_row_lo + ADDR_WIDTH'(w_x_lo);
  assign w_next_row   = r_row_base + ROW_STEP;

  assign w_accept   = wr_en_o & wr_grant_i;
  assign w_last_col = (r_cur_x == r_x_hi);
  assign w_last_row = (r_cur_y == r_y_hi);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_rad        <= '0;
      r_mat        <= '0;
      r_x_lo       <= '0;
      r_x_hi       <= '0;
      r_y_hi       <= '0;
      r_cur_x      <= '0;
      r_cur_y      <= '0;
      r_row_base   <= '0;
      wr_address_o <= '0;
      wr_data_o    <= '0;
      wr_en_o      <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done_o <= 1'b0;
          if (draw_en_i) begin
            r_x     <= w_x_clamp;
            r_y     <= w_y_clamp;
            r_rad   <= brush_radius_i;
            r_mat   <= material_i;
            busy_o  <= 1'b1;
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_x_lo       <= w_x_lo;
          r_x_hi       <= w_x_hi;
          r_y_hi       <= w_y_hi;
          r_cur_x      <= w_x_lo;
          r_cur_y      <= w_y_lo;
          r_row_base   <= w_row_lo;
          wr_address_o <= w_first_addr;
          wr_data_o    <= r_mat;
          wr_en_o      <= 1'b1;
          r_state      <= S_SWEEP;
        end

        S_SWEEP: begin
          if (w_accept) begin
            if (!w_last_col) begin
              r_cur_x      <= r_cur_x + 1'b1;
              wr_address_o <= wr_address_o + 1'b1;
            end else if (!w_last_row) begin
              r_cur_x      <= r_x_lo;
              r_cur_y      <= r_cur_y + 1'b1;
              r_row_base   <= w_next_row;
              wr_address_o <= w_next_row + ADDR_WIDTH'(r_x_lo);
            end else begin
              wr_en_o <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done_o  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          wr_en_o <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brush_stamp_writer.sv
// Scoreboard bench for brush_stamp_writer: expected writes come from a clipped-square model
// pushed at request time and are popped as the DUT's writes are accepted.
module tb_brush_stamp_writer;

  localparam int COLS = 640;
  localparam int ROWS = 400;
  localparam int AW   = $clog2(COLS*ROWS);

  logic          clk = 1'b0;
  logic          reset_i;
  logic          draw_en_i;
  logic [2:0]    brush_radius_i;
  logic [1:0]    material_i;
  logic [9:0]    mouse_x_position_i;
  logic [8:0]    mouse_y_position_i;
  logic          wr_grant_i;
  logic [AW-1:0] wr_address_o;
  logic [1:0]    wr_data_o;
  logic          wr_en_o;
  logic          busy_o;
  logic          done_o;

  brush_stamp_writer #(.COLUMNS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(2)) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .draw_en_i          (draw_en_i),
    .brush_radius_i     (brush_radius_i),
    .material_i         (material_i),
    .mouse_x_position_i (mouse_x_position_i),
    .mouse_y_position_i (mouse_y_position_i),
    .wr_grant_i         (wr_grant_i),
    .wr_address_o       (wr_address_o),
    .wr_data_o          (wr_data_o),
    .wr_en_o            (wr_en_o),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk    = 0;
  int  n_pass   = 0;
  int  n_acc    = 0;
  int  cyc      = 0;
  int  last_acc = -10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic void push_model(input int x, input int y, input int r, input int mat);
    int cx;
    int cy;
    cx = (x > COLS-1) ? COLS-1 : x;
    cy = (y > ROWS-1) ? ROWS-1 : y;
    for (int yy = cy - r; yy <= cy + r; yy++)
      for (int xx = cx - r; xx <= cx + r; xx++)
        if (xx >= 0 && xx < COLS && yy >= 0 && yy < ROWS)
          exp_q.push_back('{addr: yy*COLS + xx, data: mat});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Every write that will be accepted at the next edge must match the queue head
  always @(negedge clk) begin
    if (reset_i && wr_en_o && wr_grant_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", wr_address_o, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", wr_address_o, e.addr);
        chk("wr_data", wr_data_o, e.data);
      end
      n_acc    = n_acc + 1;
      last_acc = cyc;
    end
  end

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!done_o && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done_seen"}, done_o, 1);
    if (done_o) chk({tag, "_done_after_last"}, cyc, last_acc + 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done_o, 0);
  endtask

  task automatic run_stamp(input int x, input int y, input int r, input int mat,
                           input int exp_n, input bit stall, input string tag);
    int hold_addr;
    @(posedge clk); #1;
    mouse_x_position_i = x[9:0];
    mouse_y_position_i = y[8:0];
    brush_radius_i     = r[2:0];
    material_i         = mat[1:0];
    draw_en_i          = 1'b1;
    push_model(x, y, r, mat);
    n_acc = 0;
    @(posedge clk); #1;
    draw_en_i          = 1'b0;
    mouse_x_position_i = 10'd3;
    brush_radius_i     = 3'd7;
    chk({tag, "_setup_busy"}, busy_o, 1);
    chk({tag, "_setup_en"}, wr_en_o, 0);
    @(posedge clk); #1;
    chk({tag, "_first_en"}, wr_en_o, 1);
    if (stall) begin
      @(posedge clk); #1;
      wr_grant_i = 1'b0;
      hold_addr  = exp_q[0].addr;
      repeat (3) begin
        @(negedge clk);
        chk({tag, "_hold_addr"}, wr_address_o, hold_addr);
        chk({tag, "_hold_en"}, wr_en_o, 1);
      end
      @(posedge clk); #1;
      wr_grant_i = 1'b1;
      @(negedge clk);
      chk({tag, "_hold_addr4"}, wr_address_o, hold_addr);
    end
    wait_done(tag);
    chk({tag, "_n_writes"}, n_acc, exp_n);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    reset_i            = 1'b0;
    draw_en_i          = 1'b0;
    brush_radius_i     = '0;
    material_i         = '0;
    mouse_x_position_i = '0;
    mouse_y_position_i = '0;
    wr_grant_i         = 1'b1;
    #23;
    chk("rst_addr", wr_address_o, 0);
    chk("rst_data", wr_data_o, 0);
    chk("rst_en", wr_en_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b1;

    run_stamp(100, 50, 1, 2, 9, 1'b0, "interior");
    run_stamp(0, 0, 2, 3, 9, 1'b0, "top_left");
    run_stamp(639, 399, 1, 1, 4, 1'b0, "bot_right");
    run_stamp(100, 50, 1, 1, 9, 1'b1, "stall");
    run_stamp(1000, 450, 0, 2, 1, 1'b0, "clamp");

    // r=0 with draw_en_i held: second stamp picks up the cursor moved mid-stamp
    @(posedge clk); #1;
    mouse_x_position_i = 10'd10;
    mouse_y_position_i = 9'd20;
    brush_radius_i     = 3'd0;
    material_i         = 2'd3;
    draw_en_i          = 1'b1;
    push_model(10, 20, 0, 3);
    n_acc = 0;
    @(posedge clk); #1;
    mouse_x_position_i = 10'd300;
    mouse_y_position_i = 9'd200;
    push_model(300, 200, 0, 3);
    chk("held_busy", busy_o, 1);
    wait_done("held1");
    @(posedge clk); #1;
    chk("held_retrig_busy", busy_o, 1);
    mouse_x_position_i = 10'd5;
    mouse_y_position_i = 9'd5;
    draw_en_i          = 1'b0;
    wait_done("held2");
    chk("held_n_writes", n_acc, 2);
    chk("held_q_empty", exp_q.size(), 0);

    // Reset after the 4th accepted write of an r=2 stamp
    @(posedge clk); #1;
    mouse_x_position_i = 10'd100;
    mouse_y_position_i = 9'd50;
    brush_radius_i     = 3'd2;
    material_i         = 2'd1;
    draw_en_i          = 1'b1;
    push_model(100, 50, 2, 1);
    n_acc = 0;
    @(posedge clk); #1;
    draw_en_i = 1'b0;
    i = 0;
    while (n_acc < 4 && i < 100) begin
      @(posedge clk);
      i++;
    end
    chk("rst_mid_count", n_acc, 4);
    #1;
    reset_i = 1'b0;
    #1;
    chk("rst_mid_en", wr_en_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_done", done_o, 0);
    chk("rst_mid_addr", wr_address_o, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_done", done_o, 0);
    end
    run_stamp(320, 200, 1, 2, 9, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/brush_stamp_writer.md
Name: brush_stamp_writer

Overview:
- Sits between the mouse position tracker and the VRAM write-port mux. It replaces the single-pixel cursor write with a square brush stamp.
- On a draw request it latches the cursor position, brush radius and material. It then issues one VRAM write per granted cycle covering the square clipped to the active area, and pulses done.
- The VRAM write mux selects this block while busy_o=1. The game-state controller drives wr_grant_i low when it needs the port.

Parameters:
COLUMNS, 640, active columns (x range 0..COLUMNS-1)
ROWS, 400, active rows (y range 0..ROWS-1)
ADDR_WIDTH, $clog2(COLUMNS*ROWS), VRAM address width
DATA_WIDTH, 2, VRAM cell width (material code)

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous, active-low reset
draw_en_i  input  1  stamp request, sampled in IDLE only
brush_radius_i  input  3  brush half-width r (0..7); side = 2r+1
material_i  input  DATA_WIDTH  material code written to every stamped cell
mouse_x_position_i  input  $clog2(COLUMNS)  cursor x
mouse_y_position_i  input  $clog2(ROWS)  cursor y
wr_grant_i  input  1  VRAM port grant; a write is accepted on a cycle with wr_en_o=1 and wr_grant_i=1
wr_address_o  output  ADDR_WIDTH  VRAM write address = y*COLUMNS + x
wr_data_o  output  DATA_WIDTH  latched material
wr_en_o  output  1  write valid
busy_o  output  1  high from SETUP through SWEEP
done_o  output  1  one-cycle pulse after the final accepted write

Behaviour:
- Reset (reset_i=0, asynchronous): state=IDLE; wr_address_o=0, wr_data_o=0, wr_en_o=0, busy_o=0, done_o=0. Reset asserted mid-stamp aborts the stamp immediately; no further writes occur and done_o is not pulsed.
- States: IDLE, SETUP, SWEEP, DONE. All outputs are registered.
- IDLE: if draw_en_i=1 at edge k, latch the following and go to SETUP:
  - x/y, clamped to COLUMNS-1 / ROWS-1 if out of range;
  - r;
  - material_i.
- Bounds computed in SETUP:
  - x_lo=max(0,x-r), x_hi=min(COLUMNS-1,x+r);
  - y_lo=max(0,y-r), y_hi=min(ROWS-1,y+r);
  - use signed or widened arithmetic, with no underflow wrap.
- SETUP (1 cycle): row_base=y_lo*COLUMNS, cur_x=x_lo, cur_y=y_lo; busy_o=1. Go to SWEEP. First wr_en_o=1 appears at cycle k+2.
- SWEEP: wr_en_o=1, wr_address_o=row_base+cur_x, wr_data_o=material.
  - Address, data and wr_en_o hold stable while wr_grant_i=0.
  - On acceptance with cur_x<x_hi: cur_x+1.
  - On acceptance with cur_x=x_hi and cur_y<y_hi: cur_x=x_lo, cur_y+1, row_base+=COLUMNS. No multiplier is used in SWEEP.
  - On acceptance with cur_x=x_hi and cur_y=y_hi: go to DONE with wr_en_o=0.
  - Write order: row-major, ascending address; exactly one write per acceptance.
- DONE (1 cycle): done_o=1, busy_o=0, wr_en_o=0. Next state IDLE. If draw_en_i is still high, a new stamp begins from IDLE on the next cycle using fresh inputs.
- Input changes (position, radius, material, draw_en_i) while not in IDLE are ignored.
- Write count = (x_hi-x_lo+1)*(y_hi-y_lo+1). Full unclipped stamp = (2r+1)^2 writes; r=0 gives a single write at (x,y).
- Throughput with grant held high: 1 write/cycle. Total stamp time = 1 (SETUP) + N writes + 1 (DONE) cycles after the trigger edge.

Test Plan:
- Interior stamp: x=100, y=50, r=1, material=2'b10, grant=1.
  - Required: 9 consecutive writes to addresses 31459, 31460, 31461, 32099, 32100, 32101, 32739, 32740, 32741, all with data 2'b10.
  - Required: first wr_en_o=1 at trigger+2; done_o high one cycle after the last write.
- Top-left clip: x=0, y=0, r=2.
  - Required: exactly 9 writes to 0, 1, 2, 640, 641, 642, 1280, 1281, 1282, with no address wrap.
- Bottom-right clip: x=639, y=399, r=1.
  - Required: 4 writes to 255358, 255359, 255998, 255999, then done_o.
- Grant stall: r=1 stamp with wr_grant_i low for 3 cycles during the 2nd write.
  - Required: address 31460 held for 4 cycles, wr_en_o stays 1, still exactly 9 total accepted writes.
- r=0 with draw_en_i held high and the cursor moved mid-stamp.
  - Required: single write per stamp at the latched position; the next stamp uses the new position after done_o.
- Reset: assert reset_i=0 after the 4th write of a r=2 stamp.
  - Required: wr_en_o/busy_o/done_o go to 0 asynchronously, no done_o pulse; after release, a new request stamps normally.
